// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl                                                            |
// | Moore control sequencer for the multicycle ARM datapath: DP/LDR/STR/B.     |
// | Optional macro MULTICYCLE_CTRL_WAIT_EN adds mem_ready wait states.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
`ifdef MULTICYCLE_CTRL_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic        mov
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  flags;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        rd_pc;
  logic        ready;
  logic        unused_bits;

  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign rd_pc       = (Instr[3:0] == 4'hF);
  assign unused_bits = &{1'b0, Instr[7:4]};

`ifdef MULTICYCLE_CTRL_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Condition evaluation against the architectural flags (NZCV = [3:0])
  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic [2:0] alu_ctl;
  logic       alu_mov;
  logic       no_write;
  logic       is_logic;
  always_comb begin
    alu_ctl  = 3'b000;
    alu_mov  = 1'b0;
    no_write = 1'b0;
    is_logic = 1'b0;
    case (funct[4:1])
      4'b0100: alu_ctl = 3'b000;
      4'b0010: alu_ctl = 3'b001;
      4'b1010: begin alu_ctl = 3'b001; no_write = 1'b1; end
      4'b0000: begin alu_ctl = 3'b010; is_logic = 1'b1; end
      4'b1100: begin alu_ctl = 3'b011; is_logic = 1'b1; end
      4'b0001: begin alu_ctl = 3'b100; is_logic = 1'b1; end
      4'b1101: begin alu_mov = 1'b1; is_logic = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:   state_nx = ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b01:   state_nx = MEMADR;
          2'b00:   state_nx = funct[5] ? EXECI : EXECR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR:  state_nx = funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_nx = ready ? MEMWB : MEMRD;
      MEMWB:   state_nx = FETCH;
      MEMWR:   state_nx = ready ? FETCH : MEMWR;
      EXECR:   state_nx = ALUWB;
      EXECI:   state_nx = ALUWB;
      ALUWB:   state_nx = FETCH;
      BRANCH:  state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Outputs are decoded from the next state and registered, so CondEx for a
  // writeback state is sampled before the EXEC flag update lands.
  logic       n_pcw, n_irw, n_adr, n_mw, n_rw, n_sa, n_mov;
  logic [1:0] n_rs, n_sb;
  logic [2:0] n_ac;
  always_comb begin
    n_pcw = 1'b0; n_irw = 1'b0; n_adr = 1'b0; n_mw = 1'b0; n_rw = 1'b0;
    n_rs  = 2'b00; n_sa = 1'b0; n_sb = 2'b00; n_ac = 3'b000; n_mov = 1'b0;
    case (state_nx)
      FETCH:  begin n_pcw = 1'b1; n_irw = 1'b1; n_sa = 1'b1; n_sb = 2'b10; n_rs = 2'b10; end
      DECODE: begin n_sa = 1'b1; n_sb = 2'b10; n_rs = 2'b10; end
      MEMADR: n_sb = 2'b01;
      MEMRD:  n_adr = 1'b1;
      MEMWB: begin
        n_rs  = 2'b01;
        n_pcw = cond_ex & rd_pc;
        n_rw  = cond_ex & ~rd_pc;
      end
      MEMWR:  begin n_adr = 1'b1; n_mw = cond_ex; end
      EXECR:  begin n_ac = alu_ctl; n_mov = alu_mov; end
      EXECI:  begin n_sb = 2'b01; n_ac = alu_ctl; n_mov = alu_mov; end
      ALUWB: begin
        n_ac  = alu_ctl;
        n_mov = alu_mov;
        n_pcw = cond_ex & ~no_write & rd_pc;
        n_rw  = cond_ex & ~no_write & ~rd_pc;
      end
      BRANCH: begin n_sb = 2'b01; n_rs = 2'b10; n_pcw = cond_ex; end
      default: ;
    endcase
  end

  logic       r_pcw, r_irw, r_adr, r_mw, r_rw, r_sa, r_mov;
  logic [1:0] r_rs, r_sb;
  logic [2:0] r_ac;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
      r_pcw <= 1'b1; r_irw <= 1'b1; r_adr <= 1'b0; r_mw <= 1'b0; r_rw <= 1'b0;
      r_rs  <= 2'b10; r_sa <= 1'b1; r_sb <= 2'b10; r_ac <= 3'b000; r_mov <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == EXECR || state == EXECI) && funct[0] && cond_ex) begin
        if (is_logic)
          flags[3:2] <= ALUFlags[3:2];
        else
          flags <= ALUFlags;
      end
      r_pcw <= n_pcw; r_irw <= n_irw; r_adr <= n_adr; r_mw <= n_mw; r_rw <= n_rw;
      r_rs  <= n_rs;  r_sa  <= n_sa;  r_sb  <= n_sb;  r_ac <= n_ac; r_mov <= n_mov;
    end
  end

  // A stalled fetch must not advance PC or overwrite IR
  logic fetch_go;
  assign fetch_go = (state != FETCH) | ready;

  assign PCWrite    = r_pcw & fetch_go & ~reset;
  assign IRWrite    = r_irw & fetch_go & ~reset;
  assign AdrSrc     = r_adr & ~reset;
  assign MemWrite   = r_mw  & ~reset;
  assign RegWrite   = r_rw  & ~reset;
  assign ResultSrc  = reset ? 2'b00  : r_rs;
  assign ALUSrcA    = r_sa  & ~reset;
  assign ALUSrcB    = reset ? 2'b00  : r_sb;
  assign ALUControl = reset ? 3'b000 : r_ac;
  assign mov        = r_mov & ~reset;
  assign ImmSrc     = reset ? 2'b00  : op;
  assign RegSrc     = reset ? 2'b00  : {op == 2'b01, op == 2'b10};

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl                                                         |
// | Directed self-checking bench for multicycle_ctrl.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, mov;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
`ifdef MULTICYCLE_CTRL_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
`ifdef MULTICYCLE_CTRL_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .mov(mov)
  );

  // {PCWrite,IRWrite,AdrSrc,MemWrite,RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, mov}
  logic [13:0] outs;
  assign outs = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, mov};

  localparam logic [13:0] E_ZERO      = 14'b0;
  localparam logic [13:0] E_FETCH     = {5'b11000, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0};
  localparam logic [13:0] E_DECODE    = {5'b00000, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0};
  localparam logic [13:0] E_EXECI_ADD = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [13:0] E_WB_ADD    = {5'b00001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] E_WB_PC     = {5'b10000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] E_MEMADR    = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [13:0] E_MEMRD     = {5'b00100, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] E_MEMWB     = {5'b00001, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] E_MEMWR     = {5'b00110, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [13:0] E_BR_T      = {5'b10000, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [13:0] E_BR_F      = {5'b00000, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [13:0] E_EXECI_CMP = {5'b00000, 2'b00, 1'b0, 2'b01, 3'b001, 1'b0};
  localparam logic [13:0] E_WB_CMP    = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0};
  localparam logic [13:0] E_EXECR_MOV = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1};
  localparam logic [13:0] E_WB_MOV    = {5'b00001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Instr = 20'hE2801; ALUFlags = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== E_ZERO) begin
        errors++; $display("FAIL reset_hold%0d outs=%b exp=%b", i, outs, E_ZERO);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== E_FETCH) begin
      errors++; $display("FAIL reset_release outs=%b exp=%b", outs, E_FETCH);
    end
  endtask

  task automatic test_add_imm();
    logic [13:0] exp [0:4];
    exp = '{E_FETCH, E_DECODE, E_EXECI_ADD, E_WB_ADD, E_FETCH};
    Instr = 20'hE2801; ALUFlags = 4'b0000;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL add_imm step%0d outs=%b exp=%b", i, outs, exp[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_ldr();
    logic [13:0] exp [0:5];
    exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    Instr = 20'hE5912;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL ldr step%0d outs=%b exp=%b", i, outs, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b0110) begin
          errors++; $display("FAIL ldr_srcsel got=%b exp=0110", {ImmSrc, RegSrc});
        end
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_str();
    logic [13:0] exp [0:4];
    exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
    Instr = 20'hE5812;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL str step%0d outs=%b exp=%b", i, outs, exp[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_cmp_beq();
    logic [13:0] cmp_exp [0:4];
    logic [13:0] br_exp [0:3];
    cmp_exp = '{E_FETCH, E_DECODE, E_EXECI_CMP, E_WB_CMP, E_FETCH};
    for (int pass = 0; pass < 2; pass++) begin
      Instr = 20'hE3510;
      ALUFlags = (pass == 0) ? 4'b0100 : 4'b0000;
      br_exp = '{E_FETCH, E_DECODE, (pass == 0) ? E_BR_T : E_BR_F, E_FETCH};
      #1;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (outs !== cmp_exp[i]) begin
          errors++; $display("FAIL cmp%0d step%0d outs=%b exp=%b", pass, i, outs, cmp_exp[i]);
        end
        if (i < 4) step();
      end
      Instr = 20'h0A000; ALUFlags = 4'b0000;
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outs !== br_exp[i]) begin
          errors++; $display("FAIL beq%0d step%0d outs=%b exp=%b", pass, i, outs, br_exp[i]);
        end
        if (i == 2) begin
          checks++;
          if ({ImmSrc, RegSrc} !== 4'b1001) begin
            errors++; $display("FAIL br_srcsel got=%b exp=1001", {ImmSrc, RegSrc});
          end
        end
        if (i < 3) step();
      end
    end
  endtask

  task automatic test_mov();
    logic [13:0] exp [0:4];
    exp = '{E_FETCH, E_DECODE, E_EXECR_MOV, E_WB_MOV, E_FETCH};
    Instr = 20'hE1A03; ALUFlags = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL mov step%0d outs=%b exp=%b", i, outs, exp[i]);
      end
      if (i < 4) step();
    end
    // Z was cleared by the last CMP and MOV without S must not touch it
    Instr = 20'h0A000; ALUFlags = 4'b0000;
    step(); step();
    checks++;
    if (outs !== E_BR_F) begin
      errors++; $display("FAIL mov_flags_kept outs=%b exp=%b", outs, E_BR_F);
    end
    step();
  endtask

  task automatic test_logic_flags();
    logic [19:0] br_instr [0:3];
    logic [13:0] br_exp [0:3];
    br_instr = '{20'h2A000, 20'h4A000, 20'h6A000, 20'h1A000};
    br_exp   = '{E_BR_T, E_BR_T, E_BR_T, E_BR_F};
    Instr = 20'hE3510; ALUFlags = 4'b0011;
    step(); step(); step(); step();
    Instr = 20'hE1B03; ALUFlags = 4'b1100;
    step(); step(); step(); step();
    ALUFlags = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      Instr = br_instr[i];
      step(); step();
      checks++;
      if (outs !== br_exp[i]) begin
        errors++; $display("FAIL logic_flags br%0d outs=%b exp=%b", i, outs, br_exp[i]);
      end
      step();
    end
  endtask

  task automatic test_cond_never();
    Instr = 20'hF2801;
    step(); step(); step();
    checks++;
    if (outs !== E_ZERO) begin
      errors++; $display("FAIL cond_never_wb outs=%b exp=%b", outs, E_ZERO);
    end
    step();
  endtask

  task automatic test_undef();
    Instr = 20'hEC000;
    step();
    checks++;
    if (outs !== E_DECODE) begin
      errors++; $display("FAIL undef_decode outs=%b exp=%b", outs, E_DECODE);
    end
    step();
    checks++;
    if (outs !== E_FETCH) begin
      errors++; $display("FAIL undef_return outs=%b exp=%b", outs, E_FETCH);
    end
  endtask

  task automatic test_pc_write();
    Instr = 20'hE281F;
    step(); step(); step();
    checks++;
    if (outs !== E_WB_PC) begin
      errors++; $display("FAIL rd15_wb outs=%b exp=%b", outs, E_WB_PC);
    end
    step();
  endtask

  task automatic test_reset_mid();
    Instr = 20'hE2801;
    step(); step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== E_ZERO) begin
      errors++; $display("FAIL mid_reset_wb outs=%b exp=%b", outs, E_ZERO);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== E_FETCH) begin
      errors++; $display("FAIL mid_reset_restart outs=%b exp=%b", outs, E_FETCH);
    end
    step();
    checks++;
    if (outs !== E_DECODE) begin
      errors++; $display("FAIL mid_reset_decode outs=%b exp=%b", outs, E_DECODE);
    end
    step(); step(); step();
  endtask

`ifdef MULTICYCLE_CTRL_WAIT_EN
  task automatic test_wait();
    Instr = 20'hE2801;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs !== E_DECODE) begin
        errors++; $display("FAIL fetch_hold%0d outs=%b exp=%b", i, outs, E_DECODE);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== E_FETCH) begin
      errors++; $display("FAIL fetch_go outs=%b exp=%b", outs, E_FETCH);
    end
    step();
    checks++;
    if (outs !== E_DECODE) begin
      errors++; $display("FAIL fetch_after_wait outs=%b exp=%b", outs, E_DECODE);
    end
    step(); step(); step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_imm();
    test_ldr();
    test_str();
    test_cmp_beq();
    test_mov();
    test_logic_flags();
    test_cond_never();
    test_undef();
    test_pc_write();
    test_reset_mid();
`ifdef MULTICYCLE_CTRL_WAIT_EN
    test_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control sequencer for the multicycle variant of the ARM core. Replaces the single-cycle controller and shares one ALU and one unified memory port across fetch, decode, execute, memory and writeback.
- Decodes the data-processing, LDR/STR and B classes.
- Holds NZCV internally and evaluates condition codes.
- Drives every mux select and write enable of the multicycle datapath as a Moore FSM.

Parameters:
- none (fixed ARMv4 subset; encodings below are normative)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  Instr[31:12] from the instruction register (Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12])
- ALUFlags  in  4  NZCV from the ALU, current cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=Imm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
- mov  out  1  ALU passes SrcB (MOV)

Behaviour:
- Clocking and reset: one clock domain. Synchronous active-high reset.
- On the first rising edge with reset=1: state<=FETCH, Flags<=0000.
- While reset=1: PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs are 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 and Funct[5]=0 -> EXECR; Op=00 and Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction, no side effects).
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - BRANCH->FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (PC<=PC+4).
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. No writes; register reads of PC+8 settle here.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD (Funct[3]=U is ignored: offset always added).
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWR: AdrSrc=1, MemWrite=CondEx.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI).
- ALU decode on Funct[4:1]:
  - 0100 -> ADD
  - 0010 -> SUB
  - 1010 CMP -> SUB, NoWrite
  - 0000 -> AND
  - 1100 -> ORR
  - 0001 -> EOR
  - 1101 -> ALU=ADD with mov=1
  - Any other value -> ADD with NoWrite (no register write).
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite. Decode outputs stay valid.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
- Flags update: at the end of EXECR/EXECI, Flags<=ALUFlags when Funct[0]=1 and CondEx=1.
  - Logical ops (AND/ORR/EOR/MOV) update only N and Z; C and V are preserved.
- CondEx: combinational from Cond and the registered Flags, standard ARM table 0000..1110. Cond=1111 gives CondEx=0.
- Rd=1111 with a data-processing op or LDR: writeback goes to the PC. PCWrite=CondEx in ALUWB or MEMWB, ResultSrc unchanged, RegWrite=0.
- Outputs not listed for a state are 0.
- Reset asserted mid-instruction: no write enable is asserted in that cycle. Execution restarts at FETCH.

Optional Feature:
- Macro MULTICYCLE_CTRL_WAIT_EN.
- Defined:
  - Adds input port mem_ready (1 bit, after ReadData-side ports).
  - FETCH, MEMRD and MEMWR hold state while mem_ready=0.
  - During a FETCH hold, PCWrite=0 and IRWrite=0; both assert only in the cycle mem_ready=1.
  - During a MEMWR hold, MemWrite stays asserted.
- Undefined: no port; every memory access completes in one cycle.

Test Plan:
- reset=1 for 2 cycles, then released with Instr=E2801005 (ADD R1,R0,#5) -> FETCH,DECODE,EXECI,ALUWB. RegWrite=1 only in ALUWB. PCWrite=1 only in FETCH. Returns to FETCH after 4 cycles.
- E5912000 LDR -> 5-cycle sequence. AdrSrc=1 in MEMRD. ResultSrc=01 and RegWrite=1 in MEMWB.
- E5812000 STR -> MemWrite=1 only in MEMWR, 4 cycles. RegWrite never asserted.
- E3510000 CMP (S=1) with ALUFlags=0100, then 0A000002 BEQ -> Z latched. In BRANCH, PCWrite=1. Repeat with ALUFlags=0000 -> PCWrite=0.
- E1A03002 MOV R3,R2 -> mov=1 in EXECR. ALUWB RegWrite=1. Flags unchanged.
- With MULTICYCLE_CTRL_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> state held. PCWrite=IRWrite=0 until mem_ready=1, then asserted for exactly 1 cycle.
